// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Outputs drive the execute ALU directly; control outputs are gated by ex_valid.
module ex_issue_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [RADDR-1:0] id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [1:0]       id_a_sel,
  input  logic             id_b_sel,
  input  logic [5:0]       id_ALU_Control,
  input  logic             id_branch_op,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic [RADDR-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [RADDR-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic [XLEN-1:0]  wb_result,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  operand_A,
  output logic [XLEN-1:0]  operand_B,
  output logic [5:0]       ALU_Control,
  output logic             branch_op,
  output logic [XLEN-1:0]  ex_pc,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [XLEN-1:0]  ex_store_data
);

  logic             valid_q;
  logic [XLEN-1:0]  pc_q;
  logic [RADDR-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]  rs1_data_q, rs2_data_q, imm_q;
  logic [1:0]       a_sel_q;
  logic             b_sel_q;
  logic [5:0]       alu_q;
  logic             branch_q, regw_q, memr_q, memw_q;

  logic             load_use;
  logic [XLEN-1:0]  fwd_rs1, fwd_rs2, b_raw;
  logic             is_shift;

  assign load_use = valid_q & memr_q & (rd_q != '0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == rd_q)) | (id_uses_rs2 & (id_rs2 == rd_q)));

  assign id_ready = !ex_stall & !load_use & !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      a_sel_q    <= '0;
      b_sel_q    <= 1'b0;
      alu_q      <= '0;
      branch_q   <= 1'b0;
      regw_q     <= 1'b0;
      memr_q     <= 1'b0;
      memw_q     <= 1'b0;
    end else if (!ex_stall) begin
      if (flush || load_use) begin
        // Bubble: datapath fields are don't-care, only validity and control are cleared.
        valid_q  <= 1'b0;
        branch_q <= 1'b0;
        regw_q   <= 1'b0;
        memr_q   <= 1'b0;
        memw_q   <= 1'b0;
      end else begin
        valid_q    <= id_valid;
        pc_q       <= id_pc;
        rs1_q      <= id_rs1;
        rs2_q      <= id_rs2;
        rd_q       <= id_rd;
        rs1_data_q <= id_rs1_data;
        rs2_data_q <= id_rs2_data;
        imm_q      <= id_imm;
        a_sel_q    <= id_a_sel;
        b_sel_q    <= id_b_sel;
        alu_q      <= id_ALU_Control;
        branch_q   <= id_branch_op;
        regw_q     <= id_reg_write;
        memr_q     <= id_mem_read;
        memw_q     <= id_mem_write;
      end
    end
  end

  function automatic logic [XLEN-1:0] fwd(input logic [RADDR-1:0] idx,
                                          input logic [XLEN-1:0]  reg_val,
                                          input logic [RADDR-1:0] m_rd,
                                          input logic             m_we,
                                          input logic [XLEN-1:0]  m_val,
                                          input logic [RADDR-1:0] w_rd,
                                          input logic             w_we,
                                          input logic [XLEN-1:0]  w_val);
    logic [XLEN-1:0] r;
    r = reg_val;
    if (idx == '0)                   r = '0;
    else if (m_we && (m_rd == idx))  r = m_val;
    else if (w_we && (w_rd == idx))  r = w_val;
    return r;
  endfunction

  always_comb begin
    fwd_rs1 = fwd(rs1_q, rs1_data_q, mem_rd, mem_reg_write, mem_result,
                  wb_rd, wb_reg_write, wb_result);
    fwd_rs2 = fwd(rs2_q, rs2_data_q, mem_rd, mem_reg_write, mem_result,
                  wb_rd, wb_reg_write, wb_result);

    case (a_sel_q)
      2'b00:   operand_A = fwd_rs1;
      2'b01:   operand_A = pc_q;
      default: operand_A = '0;
    endcase

    b_raw    = b_sel_q ? imm_q : fwd_rs2;
    is_shift = (alu_q == 6'b000001) || (alu_q == 6'b000101) || (alu_q == 6'b001101);
    operand_B = is_shift ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
  end

  assign ex_valid      = valid_q;
  assign ALU_Control   = alu_q;
  assign branch_op     = branch_q & valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = regw_q & valid_q;
  assign ex_mem_read   = memr_q & valid_q;
  assign ex_mem_write  = memw_q & valid_q;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed literal cases followed by randomized traffic
// compared every cycle against a behavioural model of the issue stage.
module tb_ex_issue_stage;
  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  logic             clock, reset;
  logic             id_valid, id_ready;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RADDR-1:0] id_rs1, id_rs2, id_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic [1:0]       id_a_sel;
  logic             id_b_sel;
  logic [5:0]       id_ALU_Control;
  logic             id_branch_op, id_reg_write, id_mem_read, id_mem_write;
  logic [RADDR-1:0] mem_rd, wb_rd;
  logic             mem_reg_write, wb_reg_write;
  logic [XLEN-1:0]  mem_result, wb_result;
  logic             ex_stall, flush;
  logic             ex_valid, branch_op, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [XLEN-1:0]  operand_A, operand_B, ex_pc, ex_store_data;
  logic [5:0]       ALU_Control;
  logic [RADDR-1:0] ex_rd;

  int n_chk  = 0;
  int n_fail = 0;

  ex_issue_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_ALU_Control(id_ALU_Control),
    .id_branch_op(id_branch_op), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .operand_A(operand_A), .operand_B(operand_B),
    .ALU_Control(ALU_Control), .branch_op(branch_op), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the instruction currently sitting in EX, as a plain record.
  typedef struct {
    bit        valid;
    bit [31:0] pc, d1, d2, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [1:0]  a_sel;
    bit        b_sel;
    bit [5:0]  alu;
    bit        br, rw, mr, mw;
  } instr_t;

  instr_t m;

  function automatic bit model_load_use();
    return m.valid && m.mr && m.rd != 0 && id_valid &&
           ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
  endfunction

  function automatic bit [31:0] value_of(input bit [4:0] idx, input bit [31:0] stale);
    if (idx == 0) return 0;
    if (mem_reg_write && mem_rd == idx) return mem_result;
    if (wb_reg_write && wb_rd == idx) return wb_result;
    return stale;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m = '{default: 0};
    end else if (ex_stall) begin
      // frozen
    end else if (flush || model_load_use()) begin
      m.valid = 0;
      m.br = 0; m.rw = 0; m.mr = 0; m.mw = 0;
    end else begin
      m.valid = id_valid;   m.pc = id_pc;
      m.d1 = id_rs1_data;   m.d2 = id_rs2_data; m.imm = id_imm;
      m.rs1 = id_rs1;       m.rs2 = id_rs2;     m.rd = id_rd;
      m.a_sel = id_a_sel;   m.b_sel = id_b_sel; m.alu = id_ALU_Control;
      m.br = id_branch_op;  m.rw = id_reg_write;
      m.mr = id_mem_read;   m.mw = id_mem_write;
    end
  end

  always @(negedge clock) begin
    bit [31:0] a, b, s;
    if (reset) begin
      chk("id_ready", id_ready, !ex_stall && !flush && !model_load_use());
      chk("ex_valid", ex_valid, m.valid);
      chk("branch_op", branch_op, m.valid && m.br);
      chk("ex_reg_write", ex_reg_write, m.valid && m.rw);
      chk("ex_mem_read", ex_mem_read, m.valid && m.mr);
      chk("ex_mem_write", ex_mem_write, m.valid && m.mw);
      if (m.valid) begin
        s = value_of(m.rs2, m.d2);
        a = (m.a_sel == 0) ? value_of(m.rs1, m.d1) : (m.a_sel == 1) ? m.pc : 0;
        b = m.b_sel ? m.imm : s;
        if (m.alu == 1 || m.alu == 5 || m.alu == 13) b = b % 32;
        chk("operand_A", operand_A, a);
        chk("operand_B", operand_B, b);
        chk("ALU_Control", ALU_Control, m.alu);
        chk("ex_pc", ex_pc, m.pc);
        chk("ex_rd", ex_rd, m.rd);
        chk("ex_store_data", ex_store_data, s);
      end
    end
  end

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_a_sel = 0; id_b_sel = 0; id_ALU_Control = 0;
    id_branch_op = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    ex_stall = 0; flush = 0;
  endtask

  initial begin
    int sel;
    reset = 0;
    clear_inputs();
    #2;
    chk("rst ex_valid", ex_valid, 0);
    chk("rst operand_A", operand_A, 0);
    chk("rst operand_B", operand_B, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1;

    // Live instruction, then asynchronous reset in the middle of the cycle.
    id_valid = 1; id_pc = 32'h8; id_rd = 2; id_reg_write = 1; id_branch_op = 1;
    id_a_sel = 1;
    @(posedge clock); #1;
    chk("pre-rst ex_valid", ex_valid, 1);
    reset = 0; #1;
    chk("async ex_valid", ex_valid, 0);
    chk("async branch_op", branch_op, 0);
    chk("async ex_reg_write", ex_reg_write, 0);
    chk("async operand_A", operand_A, 0);
    chk("async ex_pc", ex_pc, 0);
    #1 reset = 1;

    // ADD x3,x1,x2
    clear_inputs();
    id_valid = 1; id_pc = 32'h10; id_rs1 = 1; id_rs2 = 2; id_rd = 3;
    id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_data = 5; id_rs2_data = 7; id_reg_write = 1;
    @(posedge clock); #1;
    chk("add operand_A", operand_A, 5);
    chk("add operand_B", operand_B, 7);
    chk("add ALU_Control", ALU_Control, 0);
    chk("add ex_valid", ex_valid, 1);

    // Forward priority MEM over WB
    clear_inputs();
    id_valid = 1; id_pc = 32'h14; id_rs1 = 4; id_uses_rs1 = 1; id_rs1_data = 32'h99; id_rd = 7;
    @(posedge clock); #1;
    id_valid = 0;
    mem_rd = 4; mem_reg_write = 1; mem_result = 32'h11;
    wb_rd = 4; wb_reg_write = 1; wb_result = 32'h22;
    #1 chk("fwd mem", operand_A, 32'h11);
    mem_reg_write = 0;
    #1 chk("fwd wb", operand_A, 32'h22);

    // x0 never forwards
    clear_inputs();
    id_valid = 1; id_pc = 32'h18; id_rs1 = 0; id_uses_rs1 = 1; id_rs1_data = 32'h55;
    mem_rd = 0; mem_reg_write = 1; mem_result = 32'hFF;
    @(posedge clock); #1;
    chk("x0 operand_A", operand_A, 0);

    // Load-use: LW x5 then ADD x6,x5,x1
    clear_inputs();
    id_valid = 1; id_pc = 32'h20; id_rd = 5; id_rs1 = 1; id_uses_rs1 = 1;
    id_b_sel = 1; id_imm = 4; id_mem_read = 1; id_reg_write = 1;
    @(posedge clock); #1;
    clear_inputs();
    id_valid = 1; id_pc = 32'h24; id_rs1 = 5; id_rs2 = 1; id_rd = 6;
    id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs2_data = 3; id_reg_write = 1;
    #1 chk("lu id_ready", id_ready, 0);
    @(posedge clock); #1;
    chk("lu bubble ex_valid", ex_valid, 0);
    chk("lu bubble branch_op", branch_op, 0);
    chk("lu bubble ex_reg_write", ex_reg_write, 0);
    chk("lu id_ready after", id_ready, 1);
    wb_rd = 5; wb_reg_write = 1; wb_result = 32'h40;
    @(posedge clock); #1;
    chk("lu issue ex_valid", ex_valid, 1);
    chk("lu issue operand_A", operand_A, 32'h40);
    chk("lu issue ex_rd", ex_rd, 6);

    // Stall dominates flush, then flush alone bubbles
    id_pc = 32'h28; ex_stall = 1; flush = 1;
    #1 chk("stall id_ready", id_ready, 0);
    @(posedge clock); #1;
    chk("stall ex_valid", ex_valid, 1);
    chk("stall ex_pc", ex_pc, 32'h24);
    ex_stall = 0;
    @(posedge clock); #1;
    chk("flush ex_valid", ex_valid, 0);

    // SLLI shift-amount mask, then AUIPC
    clear_inputs();
    id_valid = 1; id_pc = 32'h30; id_rs1 = 1; id_uses_rs1 = 1; id_rs1_data = 3;
    id_b_sel = 1; id_imm = 32'h25; id_ALU_Control = 6'b000001; id_rd = 8; id_reg_write = 1;
    @(posedge clock); #1;
    chk("slli operand_B", operand_B, 5);
    clear_inputs();
    id_valid = 1; id_pc = 32'h100; id_a_sel = 2'b01; id_b_sel = 1; id_imm = 32'h1000;
    id_rd = 9; id_reg_write = 1;
    @(posedge clock); #1;
    chk("auipc operand_A", operand_A, 32'h100);
    chk("auipc operand_B", operand_B, 32'h1000);

    // Randomized traffic, small register space to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      id_valid = ($urandom_range(0, 9) < 8);
      id_pc = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_a_sel = 2'($urandom); id_b_sel = 1'($urandom);
      sel = $urandom_range(0, 4);
      id_ALU_Control = (sel == 0) ? 6'd1 : (sel == 1) ? 6'd5 : (sel == 2) ? 6'd13 : 6'($urandom);
      id_branch_op = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = ($urandom_range(0, 9) < 4); id_mem_write = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom); mem_result = $urandom;
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom); wb_result = $urandom;
      ex_stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) < 1);
    end

    @(posedge clock); #1;
    clear_inputs();
    repeat (3) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline register and operand-issue logic sitting directly upstream of the execute ALU.
- Captures a decoded instruction, resolves RAW hazards by forwarding from the MEM and WB stages, and inserts a bubble on load-use.
- Honours downstream stall and branch flush.
- Drives operand_A, operand_B, ALU_Control and branch_op straight into the ALU.

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register-index width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the decode instruction this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  RADDR  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction reads rs1 / rs2
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_a_sel  in  2  operand A source: 00 rs1, 01 pc, 10 zero
- id_b_sel  in  1  operand B source: 0 rs2, 1 imm
- id_ALU_Control  in  6  ALU opcode
- id_branch_op  in  1  conditional branch
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- mem_rd  in  RADDR  destination index of the MEM-stage instruction
- mem_reg_write  in  1  MEM-stage instruction writes rd
- mem_result  in  XLEN  MEM-stage result
- wb_rd  in  RADDR  destination index of the WB-stage instruction
- wb_reg_write  in  1  WB-stage instruction writes rd
- wb_result  in  XLEN  WB-stage result
- ex_stall  in  1  downstream freeze
- flush  in  1  taken branch/jump redirect
- ex_valid  out  1  EX holds a live instruction
- operand_A, operand_B  out  XLEN  ALU operands
- ALU_Control  out  6  ALU opcode
- branch_op  out  1  id_branch_op gated by ex_valid
- ex_pc  out  XLEN  PC of the EX instruction
- ex_rd  out  RADDR  destination index of the EX instruction
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control bits, gated by ex_valid
- ex_store_data  out  XLEN  forwarded rs2 value

Behaviour:
- Reset (asynchronous, active-low): every register clears; all outputs are 0, including ex_valid, branch_op and ex_reg_write.
- Latency: one cycle. An instruction accepted at edge N appears on the outputs after edge N.
- load_use = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- id_ready = !ex_stall & !load_use & !flush. It is combinational.
- Register update priority:
  1. ex_stall=1: hold all state. flush is ignored; the producer re-asserts flush once ex_stall drops.
  2. flush=1: load a bubble (ex_valid=0, control bits 0).
  3. load_use=1: load a bubble. The ID instruction is held upstream, so it issues one cycle later and then forwards from WB.
  4. Otherwise load the ID fields; ex_valid = id_valid.
- Forwarding is combinational on the registered rs1/rs2 indices and data. Sources are MEM first, then WB, then the registered value.
  - A source matches only when its reg_write=1, its rd equals the index, and the index is not 0.
  - Index 0 always yields 0, regardless of data.
- operand_A: fwd_rs1, ex_pc or 0 according to a_sel. a_sel=11 yields 0.
- operand_B: fwd_rs2 or imm according to b_sel.
- For ALU_Control 000001, 000101 and 001101 (shift ops), operand_B is zero-extended from bits [4:0].
- ex_store_data is always fwd_rs2.
- Contract: MEM/WB inputs remain stable while ex_stall=1, because the whole back end freezes together.
- Bubble outputs: operand_A, operand_B and ALU_Control are don't-care, but branch_op, ex_reg_write, ex_mem_read and ex_mem_write must all be 0.
- Simultaneous load_use and flush: flush wins (bubble); the stale load_use request disappears with the redirect.

Test Plan:
- Reset mid-operation: assert reset low while ex_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; after release with id_valid=1 ADD x3,x1,x2 (rs1_data=5, rs2_data=7) -> next cycle operand_A=5, operand_B=7, ALU_Control=000000, ex_valid=1.
- Forward priority: EX x4 rs1; mem_rd=4 mem_result=0x11 and wb_rd=4 wb_result=0x22, both reg_write=1 -> operand_A=0x11. With mem_reg_write=0 -> operand_A=0x22.
- x0: rs1=0, mem_rd=0 mem_reg_write=1 mem_result=0xFF -> operand_A=0.
- Load-use: EX LW x5 (ex_mem_read=1), ID ADD x6,x5,x1 -> id_ready=0 for 1 cycle and EX becomes a bubble (branch_op=0, ex_reg_write=0). Next cycle ADD issues; with wb_rd=5 wb_result=0x40 -> operand_A=0x40.
- Stall/flush: ex_stall=1 with flush=1 -> registers held, id_ready=0. ex_stall=0 with flush=1 -> next cycle ex_valid=0.
- Shift mask: SLLI with imm=0x00000025 -> operand_B=5. AUIPC at pc=0x100 with imm=0x1000 -> operand_A=0x100, operand_B=0x1000.
